// File: rtl/approx_mul_pkg.sv
// Shared types and constant helpers for the sequential approximate multiplier.
// APPROX_MUL_COMP_EN enables the rounding compensation seeded into the accumulator.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Product is at most 32 bits wide (WIDTH <= 16), so helpers return 32-bit values.
    function automatic logic [31:0] trunc_mask(input int width, input int trunc);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if ((i < 2 * width) && (i >= trunc)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] comp_init(input int trunc);
        logic en;
`ifdef APPROX_MUL_COMP_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return (en && (trunc > 0)) ? (32'd1 << (trunc - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/approx_pp_row.sv
// One shifted partial-product row with the truncated low columns forced to zero.
module approx_pp_row
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 0
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] cnt,
    input  logic                     b_bit,
    output logic [2*WIDTH-1:0]       row
);

    localparam logic [31:0]          MASK_FULL = trunc_mask(WIDTH, TRUNC);
    localparam logic [2*WIDTH-1:0]   MASK      = MASK_FULL[2*WIDTH-1:0];

    logic [2*WIDTH-1:0] shifted;

    always_comb begin
        shifted = {{WIDTH{1'b0}}, a} << cnt;
        row     = b_bit ? (shifted & MASK) : '0;
    end

endmodule

// File: rtl/approx_mul_seq.sv
// Radix-2 shift-add approximate multiplier behind a valid/ready stream interface.
// Define APPROX_MUL_COMP_EN to seed the accumulator with 2^(TRUNC-1) when TRUNC > 0.
module approx_mul_seq
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds data stable while valid is high and ready is low.

    localparam int                CW        = $clog2(WIDTH);
    localparam int                PW        = 2 * WIDTH;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [31:0]       INIT_FULL = comp_init(TRUNC);
    localparam logic [PW-1:0]     ACC_INIT  = INIT_FULL[PW-1:0];

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     row;
    logic [CW-1:0]     cnt_q;
    logic              accept;

    approx_pp_row #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_row (
        .a     (a_q),
        .cnt   (cnt_q),
        .b_bit (b_q[cnt_q]),
        .row   (row)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            BUSY: if (cnt_q == CNT_LAST) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = in_valid && in_ready;
        // A new operand pair accepted while leaving DONE goes straight to BUSY.
        if (accept) state_d = BUSY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                acc_q <= ACC_INIT;
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                acc_q <= acc_q + row;
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    assign out_p = acc_q;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Self-checking bench for approx_mul_seq: directed stream scenarios plus a
// randomized sweep over WIDTH=4 and WIDTH=12 for every legal TRUNC.
module tb_approx_mul_seq;

`ifdef APPROX_MUL_COMP_EN
    localparam bit COMP_ON = 1'b1;
`else
    localparam bit COMP_ON = 1'b0;
`endif
    localparam int N_SWEEP = 18;

    logic clk = 1'b0;
    logic rst;
    logic rst_sw;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sweep_done = 0;

    always #5 clk = ~clk;

    // Reference product: sum of every surviving bit product a_j*b_i*2^(i+j).
    function automatic logic [63:0] golden(input int w, input int t,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < w; i++) begin
            for (int j = 0; j < w; j++) begin
                if (a[j] && b[i] && ((i + j) >= t)) s += 64'd1 << (i + j);
            end
        end
        if (COMP_ON && (t > 0)) s += 64'd1 << (t - 1);
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Main DUT: exact product, WIDTH=8.
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_p;

    approx_mul_seq #(.WIDTH(8), .TRUNC(0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    // Truncating DUT: WIDTH=8, TRUNC=4.
    logic        tr_iv, tr_ir, tr_ov, tr_ordy;
    logic [7:0]  tr_a, tr_b;
    logic [15:0] tr_p;

    approx_mul_seq #(.WIDTH(8), .TRUNC(4)) u_tr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (tr_iv),
        .in_ready  (tr_ir),
        .in_a      (tr_a),
        .in_b      (tr_b),
        .out_valid (tr_ov),
        .out_ready (tr_ordy),
        .out_p     (tr_p)
    );

    task automatic main_wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, 8);
    endtask

    task automatic tr_op(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        tr_a = a; tr_b = b; tr_iv = 1'b1;
        @(negedge clk);
        tr_iv = 1'b0; tr_a = 8'($urandom); tr_b = 8'($urandom);
        n = 0;
        while (!tr_ov && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("trunc_latency", n, 8);
        check($sformatf("trunc_%0dx%0d", a, b), tr_p, golden(8, 4, a, b));
        tr_ordy = 1'b1;
        @(negedge clk);
        tr_ordy = 1'b0;
    endtask

    // Randomized sweep, one DUT per (WIDTH, TRUNC) pair.
    for (genvar gi = 0; gi < N_SWEEP; gi++) begin : g_sw
        localparam int W = (gi < 5) ? 4 : 12;
        localparam int T = (gi < 5) ? gi : gi - 5;
        logic             iv, ir, ov, ordy;
        logic [W-1:0]     ia, ib;
        logic [2*W-1:0]   op;

        approx_mul_seq #(.WIDTH(W), .TRUNC(T)) u_sw (
            .clk       (clk),
            .rst       (rst_sw),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (ia),
            .in_b      (ib),
            .out_valid (ov),
            .out_ready (ordy),
            .out_p     (op)
        );

        initial begin
            logic [2*W-1:0] exp_q[$];
            int n;
            iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0;
            @(negedge clk);
            while (rst_sw) @(negedge clk);
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                ia = (k == 0) ? '1 : W'($urandom);
                ib = (k == 0) ? '1 : W'($urandom);
                iv = 1'b1;
                exp_q.push_back((2*W)'(golden(W, T, ia, ib)));
                n = 0;
                while (!ir && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                iv = 1'b0; ia = W'($urandom); ib = W'($urandom);
                n = 0;
                while (!ov && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("sw%0d_%0d_latency", W, T), n, W);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check($sformatf("sw%0d_%0d_p", W, T), op, exp_q.pop_front());
                ordy = 1'b1;
                @(negedge clk);
                ordy = 1'b0;
            end
            sweep_done++;
        end
    end

    initial begin
        logic [7:0]  pa [3] = '{8'd3, 8'd7, 8'd0};
        logic [7:0]  pb [3] = '{8'd5, 8'd9, 8'd200};
        logic [15:0] vals[$];
        int          vcyc[$];
        int          idx, n;
        bit          fire, seen;

        rst = 1'b1; rst_sw = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        tr_iv = 1'b0; tr_ordy = 1'b0; tr_a = '0; tr_b = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0; rst_sw = 1'b0;

        // Exact 255 x 255 with latency measurement.
        @(negedge clk);
        in_a = 8'd255; in_b = 8'd255; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
        main_wait_valid("exact_latency");
        check("exact_p", out_p, golden(8, 0, 255, 255));

        // Backpressure: result held, second request refused.
        in_a = 8'd1; in_b = 8'd2; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_p", out_p, golden(8, 0, 255, 255));
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_in_ready_rise", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("bp_single_delivery", seen, 0);

        // Back-to-back with out_ready held high.
        out_ready = 1'b1; idx = 0; fire = 1'b0;
        in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                vcyc.push_back(c);
                vals.push_back(out_p);
            end
            fire = in_valid && in_ready;
            @(negedge clk);
            if (fire) begin
                idx++;
                if (idx < 3) begin
                    in_a = pa[idx]; in_b = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check("b2b_count", vals.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (vals.size() > k) check($sformatf("b2b_p%0d", k), vals[k], golden(8, 0, pa[k], pb[k]));
        end
        for (int k = 1; k < 3; k++) begin
            if (vcyc.size() > k) check($sformatf("b2b_gap%0d", k), vcyc[k] - vcyc[k-1], 9);
        end

        // Reset in the middle of an operation.
        @(negedge clk);
        in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_p", out_p, 0);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        in_a = 8'd6; in_b = 8'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        main_wait_valid("midrst_latency");
        check("midrst_p", out_p, golden(8, 0, 6, 7));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Truncated columns.
        tr_op(8'd15, 8'd15);
        tr_op(8'd255, 8'd255);
        tr_op(8'd200, 8'd37);

        n = 0;
        while (sweep_done < N_SWEEP && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_complete", sweep_done, N_SWEEP);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
